memory_stage_lsu: RTL and testbench
===================================

// Module: memory_stage_lsu
// PURPOSE
//  Parametrised RV32I memory (M) stage with its M/W pipeline register and an internal data RAM.
//  Supports byte, halfword and word loads/stores, with sign or zero extension per funct3.
//  Has a configurable RAM access latency; the stage stalls upstream while an access is in flight.
//  Detects misaligned accesses. Sits between the execute stage and the writeback stage.
// PARAMETERS
//  XLEN        32    data/address width
//  DEPTH_WORDS 1024  RAM depth in XLEN words (power of 2); AW = log2(DEPTH_WORDS)
//  MEM_LATENCY 1     cycles from a memory op entering M to its result at W (1..8)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous reset, active low
//  ValidM       in   1     M-stage instruction valid
//  RegWriteM    in   1     instruction writes rd
//  MemReadM     in   1     load
//  MemWriteM    in   1     store
//  Funct3M      in   3     000 B, 001 H, 010 W, 100 BU, 101 HU
//  ResultSrcM   in   2     writeback mux select (passed through)
//  RD_M         in   5     destination register
//  PCPlus4M     in   XLEN  passed through
//  ALU_ResultM  in   XLEN  effective address / ALU result
//  WriteDataM   in   XLEN  store data (low bytes used for B/H)
//  StallM       out  1     hold M inputs and all upstream stages
//  ValidW,RegWriteW out 1  registered to W
//  ResultSrcW   out  2     registered
//  RD_W         out  5     registered
//  PCPlus4W,ALU_ResultW,ReadDataW out XLEN  registered; ReadDataW is extended load data
//  MisalignW    out  1     registered; the op at W was misaligned and suppressed
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all W outputs are 0; StallM=0; FSM goes to IDLE; wait counter is 0.
//   - A pending store is discarded and not written. RAM contents are not cleared.
//  Word index = ALU_ResultM[AW+1:2]; higher address bits are ignored, so addresses wrap modulo RAM size.
//  Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   - No RAM access and no stall.
//   - Next edge: ValidW=1, RegWriteW=0, MisalignW=1, ReadDataW=0.
//  Non-memory op, or ValidM=0: W regs load the M inputs at the next edge (1-cycle latency).
//   - ValidW=ValidM, ReadDataW=0.
//  Memory op with MEM_LATENCY=1:
//   - Store bytes are written at that edge.
//   - Load data is read combinationally and registered into ReadDataW at that edge.
//  Memory op with MEM_LATENCY=N>1, FSM IDLE->BUSY:
//   - In IDLE the op is seen; StallM=1 combinationally. At the edge, cnt<=N-2 and state goes to BUSY.
//   - In BUSY: StallM=1 while cnt!=0; cnt decrements each edge.
//   - When cnt==0: StallM=0 and the access completes at that edge (store commit or load capture).
//     W regs load and state returns to IDLE.
//   - While stalled, W regs load a bubble: ValidW=0, RegWriteW=0, other fields hold.
//   - Upstream holds the M inputs stable during StallM; the RTL re-samples them at completion.
//  Stores: SB writes lane addr[1:0] from WriteDataM[7:0]; SH writes lanes {addr[1],0}/+1 from [15:0];
//   SW writes all 4 lanes. Other lanes are unchanged.
//  Loads: LB/LH sign-extend, LBU/LHU zero-extend the selected lane(s); LW returns the full word.
//  Undefined funct3 (011,110,111) is treated as W.
//  MemReadM and MemWriteM both high: the store takes priority and ReadDataW=0.
//  RAW: a load that follows a store to the same word sees the stored data (the store commits first).
//  Back-to-back memory ops: each pays the full MEM_LATENCY; there is no overlap.
// TESTING
//  1. Reset mid-BUSY (MEM_LATENCY=3, SW pending) -> outputs 0, StallM=0; a later LW of that addr
//     returns the old value.
//  2. SW 0xDEADBEEF @0x10, then LB @0x13 -> ReadDataW=0xFFFFFFDE; LBU -> 0x000000DE;
//     LH @0x12 -> 0xFFFFDEAD.
//  3. SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF.
//  4. MEM_LATENCY=4, LW: StallM high for 3 cycles, ValidW=0 during the stall, data at W on cycle 4;
//     an ALU op behind it reaches W on cycle 5.
//  5. LW @0x06 -> MisalignW=1, RegWriteW=0, no stall, RAM unchanged; SH @0x01 -> no write.
//  6. Wrap: DEPTH_WORDS=1024, SW @0x1000 then LW @0x0 -> same data; ALU op -> ALU_ResultW
//     and PCPlus4W pass through after 1 cycle.

Source files
------------

// File: rtl/memory_stage_lsu_if.sv
// Execute-to-writeback bundle of the memory stage: M-stage inputs, stall back-pressure and
// the registered W-stage outputs.
interface memory_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic            valid_m;
  logic            reg_write_m;
  logic            mem_read_m;
  logic            mem_write_m;
  logic [2:0]      funct3_m;
  logic [1:0]      result_src_m;
  logic [4:0]      rd_m;
  logic [XLEN-1:0] pc_plus4_m;
  logic [XLEN-1:0] alu_result_m;
  logic [XLEN-1:0] write_data_m;
  logic            stall_m;
  logic            valid_w;
  logic            reg_write_w;
  logic [1:0]      result_src_w;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] pc_plus4_w;
  logic [XLEN-1:0] alu_result_w;
  logic [XLEN-1:0] read_data_w;
  logic            misalign_w;

  modport master (
    output valid_m, reg_write_m, mem_read_m, mem_write_m, funct3_m, result_src_m, rd_m,
           pc_plus4_m, alu_result_m, write_data_m,
    input  stall_m, valid_w, reg_write_w, result_src_w, rd_w, pc_plus4_w, alu_result_w,
           read_data_w, misalign_w
  );

  modport slave (
    input  valid_m, reg_write_m, mem_read_m, mem_write_m, funct3_m, result_src_m, rd_m,
           pc_plus4_m, alu_result_m, write_data_m,
    output stall_m, valid_w, reg_write_w, result_src_w, rd_w, pc_plus4_w, alu_result_w,
           read_data_w, misalign_w
  );
endinterface

// File: rtl/memory_stage_lsu.sv
// RV32I memory stage: byte-lane data RAM with configurable access latency, misalignment
// suppression, load extension and the M/W pipeline register.
module memory_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  memory_stage_lsu_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam int         NB       = XLEN / 8;
  localparam bit         MULTI    = (MEM_LATENCY > 1);
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 2);
  localparam logic       IDLE     = 1'b0;
  localparam logic       BUSY     = 1'b1;

  logic [XLEN-1:0] ram [DEPTH_WORDS];

  logic            state;
  logic [2:0]      cnt;
  logic [AW-1:0]   word_idx;
  logic [1:0]      addr_lo;
  logic            is_half, is_word;
  logic            is_mem, misalign, mem_op, busy;
  logic            stall, access_done, store_en, load_en;
  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] write_lanes;
  logic [XLEN-1:0] read_word, load_ext;
  logic [7:0]      read_byte;
  logic [15:0]     read_half;

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign word_idx = bus.alu_result_m[AW+1:2];
  assign addr_lo  = bus.alu_result_m[1:0];
  assign is_half  = (bus.funct3_m[1:0] == 2'b01);
  assign is_word  = bus.funct3_m[1];

  assign is_mem   = bus.valid_m & (bus.mem_read_m | bus.mem_write_m);
  assign misalign = is_mem & ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));
  assign mem_op   = is_mem & ~misalign;
  assign busy     = (state == BUSY);

  // Stall covers the IDLE cycle that first sees the op and every BUSY cycle before the last.
  assign stall       = rst & MULTI & ((~busy & mem_op) | (busy & (cnt != 3'd0)));
  assign access_done = mem_op & (~MULTI | (busy & (cnt == 3'd0)));
  assign store_en    = access_done & bus.mem_write_m & rst;
  assign load_en     = access_done & bus.mem_read_m & ~bus.mem_write_m;
  assign bus.stall_m = stall;

  // NOTE: combinational blocks assign a default to every output first so no latch is inferred.
  always_comb begin
    byte_en     = '0;
    write_lanes = bus.write_data_m;
    case (bus.funct3_m[1:0])
      2'b00: begin
        byte_en     = NB'(1) << addr_lo;
        write_lanes = {NB{bus.write_data_m[7:0]}};
      end
      2'b01: begin
        byte_en     = NB'(2'b11) << {addr_lo[1], 1'b0};
        write_lanes = {(NB/2){bus.write_data_m[15:0]}};
      end
      default: byte_en = '1;
    endcase
  end

  always_comb begin
    read_word = ram[word_idx];
    read_byte = read_word[{addr_lo, 3'b000} +: 8];
    read_half = read_word[{addr_lo[1], 4'b0000} +: 16];
    case (bus.funct3_m[1:0])
      2'b00:   load_ext = {{(XLEN-8){~bus.funct3_m[2] & read_byte[7]}}, read_byte};
      2'b01:   load_ext = {{(XLEN-16){~bus.funct3_m[2] & read_half[15]}}, read_half};
      default: load_ext = read_word;
    endcase
  end

  // NOTE: the RAM has no reset port; its contents survive rst and only the write enable is gated.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (store_en && byte_en[b]) ram[word_idx][8*b +: 8] <= write_lanes[8*b +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else if (MULTI) begin
      if (!busy) begin
        if (mem_op) begin
          state <= BUSY;
          cnt   <= CNT_INIT;
        end
      end else if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_w      <= 1'b0;
      bus.reg_write_w  <= 1'b0;
      bus.result_src_w <= 2'b00;
      bus.rd_w         <= 5'd0;
      bus.pc_plus4_w   <= '0;
      bus.alu_result_w <= '0;
      bus.read_data_w  <= '0;
      bus.misalign_w   <= 1'b0;
    end else if (stall) begin
      // Bubble into W while the access is in flight; payload fields hold.
      bus.valid_w     <= 1'b0;
      bus.reg_write_w <= 1'b0;
    end else begin
      bus.valid_w      <= bus.valid_m;
      bus.reg_write_w  <= bus.valid_m & bus.reg_write_m & ~misalign;
      bus.result_src_w <= bus.result_src_m;
      bus.rd_w         <= bus.rd_m;
      bus.pc_plus4_w   <= bus.pc_plus4_m;
      bus.alu_result_w <= bus.alu_result_m;
      bus.read_data_w  <= load_en ? load_ext : '0;
      bus.misalign_w   <= misalign;
    end
  end
endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: three instances (latency 1, 3, 4) share one stimulus bus;
// only the selected instance sees valid_m. Expected W records go through a scoreboard queue.
module tb_memory_stage_lsu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid_m, reg_write_m, mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_plus4_m, alu_result_m, write_data_m;
  int          sel = 0;

  memory_stage_lsu_if #(.XLEN(32)) if1 ();
  memory_stage_lsu_if #(.XLEN(32)) if3 ();
  memory_stage_lsu_if #(.XLEN(32)) if4 ();

  assign if1.valid_m = valid_m & (sel == 0);
  assign if3.valid_m = valid_m & (sel == 1);
  assign if4.valid_m = valid_m & (sel == 2);
  assign if1.reg_write_m = reg_write_m;   assign if3.reg_write_m = reg_write_m;   assign if4.reg_write_m = reg_write_m;
  assign if1.mem_read_m = mem_read_m;     assign if3.mem_read_m = mem_read_m;     assign if4.mem_read_m = mem_read_m;
  assign if1.mem_write_m = mem_write_m;   assign if3.mem_write_m = mem_write_m;   assign if4.mem_write_m = mem_write_m;
  assign if1.funct3_m = funct3_m;         assign if3.funct3_m = funct3_m;         assign if4.funct3_m = funct3_m;
  assign if1.result_src_m = result_src_m; assign if3.result_src_m = result_src_m; assign if4.result_src_m = result_src_m;
  assign if1.rd_m = rd_m;                 assign if3.rd_m = rd_m;                 assign if4.rd_m = rd_m;
  assign if1.pc_plus4_m = pc_plus4_m;     assign if3.pc_plus4_m = pc_plus4_m;     assign if4.pc_plus4_m = pc_plus4_m;
  assign if1.alu_result_m = alu_result_m; assign if3.alu_result_m = alu_result_m; assign if4.alu_result_m = alu_result_m;
  assign if1.write_data_m = write_data_m; assign if3.write_data_m = write_data_m; assign if4.write_data_m = write_data_m;

  memory_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(if1));
  memory_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(3)) dut_l3 (.clk(clk), .rst(rst), .bus(if3));
  memory_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(4)) dut_l4 (.clk(clk), .rst(rst), .bus(if4));

  // Outputs of the currently selected instance.
  logic        c_stall, c_valid, c_regw, c_mis;
  logic [1:0]  c_rsrc;
  logic [4:0]  c_rd;
  logic [31:0] c_pc, c_alu, c_rdata;
  assign c_stall = (sel == 0) ? if1.stall_m      : (sel == 1) ? if3.stall_m      : if4.stall_m;
  assign c_valid = (sel == 0) ? if1.valid_w      : (sel == 1) ? if3.valid_w      : if4.valid_w;
  assign c_regw  = (sel == 0) ? if1.reg_write_w  : (sel == 1) ? if3.reg_write_w  : if4.reg_write_w;
  assign c_mis   = (sel == 0) ? if1.misalign_w   : (sel == 1) ? if3.misalign_w   : if4.misalign_w;
  assign c_rsrc  = (sel == 0) ? if1.result_src_w : (sel == 1) ? if3.result_src_w : if4.result_src_w;
  assign c_rd    = (sel == 0) ? if1.rd_w         : (sel == 1) ? if3.rd_w         : if4.rd_w;
  assign c_pc    = (sel == 0) ? if1.pc_plus4_w   : (sel == 1) ? if3.pc_plus4_w   : if4.pc_plus4_w;
  assign c_alu   = (sel == 0) ? if1.alu_result_w : (sel == 1) ? if3.alu_result_w : if4.alu_result_w;
  assign c_rdata = (sel == 0) ? if1.read_data_w  : (sel == 1) ? if3.read_data_w  : if4.read_data_w;

  typedef struct {
    string       name;
    logic        valid, regw, mrd, mwr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic        valid, regw, mis;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] pc, alu, rdata;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic v, input logic rw, input logic rd,
                              input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] er, input logic em);
    vec_t t;
    t.name = nm; t.valid = v; t.regw = rw; t.mrd = rd; t.mwr = wr; t.f3 = f3;
    t.addr = a; t.wdata = wd; t.exp_rdata = er; t.exp_mis = em;
    return t;
  endfunction

  task automatic idle();
    valid_m = 1'b0; reg_write_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
    funct3_m = 3'b010; result_src_m = 2'b00; rd_m = 5'd0;
    pc_plus4_m = '0; alu_result_m = '0; write_data_m = '0;
  endtask

  // Drive a vector and push its expected W record; pass-through fields come from a running tag.
  task automatic drive(input vec_t v);
    exp_t e;
    tag++;
    valid_m = v.valid; reg_write_m = v.regw; mem_read_m = v.mrd; mem_write_m = v.mwr;
    funct3_m = v.f3; alu_result_m = v.addr; write_data_m = v.wdata;
    result_src_m = 2'(tag); rd_m = 5'(tag); pc_plus4_m = 32'h0000_1000 + 32'(tag * 4);
    e.name = v.name; e.valid = v.valid; e.regw = v.valid & v.regw & ~v.exp_mis; e.mis = v.exp_mis;
    e.rsrc = 2'(tag); e.rd = 5'(tag); e.pc = 32'h0000_1000 + 32'(tag * 4);
    e.alu = v.addr; e.rdata = v.exp_rdata;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, ".valid"}, 32'(c_valid), 32'(e.valid));
      check({e.name, ".regw"},  32'(c_regw),  32'(e.regw));
      check({e.name, ".mis"},   32'(c_mis),   32'(e.mis));
      check({e.name, ".rsrc"},  32'(c_rsrc),  32'(e.rsrc));
      check({e.name, ".rd"},    32'(c_rd),    32'(e.rd));
      check({e.name, ".pc"},    c_pc,         e.pc);
      check({e.name, ".alu"},   c_alu,        e.alu);
      check({e.name, ".rdata"}, c_rdata,      e.rdata);
    end
  endtask

  // Hold the op through any stall (bounded), checking bubbles, then compare at completion.
  task automatic run_op(input vec_t v, input int budget);
    int n;
    drive(v);
    #1;
    n = 0;
    while (c_stall && n < budget) begin
      @(posedge clk); #1;
      check({v.name, ".bubble_valid"}, 32'(c_valid), 32'd0);
      n++;
    end
    check({v.name, ".stall_timeout"}, 32'(c_stall), 32'd0);
    @(posedge clk); #1;
    compare_front();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk("sw_base",   1, 0, 0, 1, 3'b010, 32'h0000_0000, 32'h1122_3344, 32'h0, 0));
    tbl.push_back(mk("sh_mis",    1, 0, 0, 1, 3'b001, 32'h0000_0001, 32'h0000_AAAA, 32'h0, 1));
    tbl.push_back(mk("lw_unchg",  1, 1, 1, 0, 3'b010, 32'h0000_0000, 32'h0, 32'h1122_3344, 0));
    tbl.push_back(mk("sw_dead",   1, 0, 0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0));
    tbl.push_back(mk("lb_13",     1, 1, 1, 0, 3'b000, 32'h0000_0013, 32'h0, 32'hFFFF_FFDE, 0));
    tbl.push_back(mk("lbu_13",    1, 1, 1, 0, 3'b100, 32'h0000_0013, 32'h0, 32'h0000_00DE, 0));
    tbl.push_back(mk("lh_12",     1, 1, 1, 0, 3'b001, 32'h0000_0012, 32'h0, 32'hFFFF_DEAD, 0));
    tbl.push_back(mk("lhu_12",    1, 1, 1, 0, 3'b101, 32'h0000_0012, 32'h0, 32'h0000_DEAD, 0));
    tbl.push_back(mk("sb_11",     1, 0, 0, 1, 3'b000, 32'h0000_0011, 32'h1234_5655, 32'h0, 0));
    tbl.push_back(mk("lw_10",     1, 1, 1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 0));
    tbl.push_back(mk("lb_11_pos", 1, 1, 1, 0, 3'b000, 32'h0000_0011, 32'h0, 32'h0000_0055, 0));
    tbl.push_back(mk("lb_10_neg", 1, 1, 1, 0, 3'b000, 32'h0000_0010, 32'h0, 32'hFFFF_FFEF, 0));
    tbl.push_back(mk("lw_mis_06", 1, 1, 1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1));
    tbl.push_back(mk("sw_wrap",   1, 0, 0, 1, 3'b010, 32'h0000_1000, 32'hCAFE_F00D, 32'h0, 0));
    tbl.push_back(mk("lw_wrap",   1, 1, 1, 0, 3'b010, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 0));
    tbl.push_back(mk("sh_02",     1, 0, 0, 1, 3'b001, 32'h0000_0002, 32'h0000_BEEF, 32'h0, 0));
    tbl.push_back(mk("lw_after_sh", 1, 1, 1, 0, 3'b010, 32'h0000_0000, 32'h0, 32'hBEEF_F00D, 0));
    tbl.push_back(mk("lh_00",     1, 1, 1, 0, 3'b001, 32'h0000_0000, 32'h0, 32'hFFFF_F00D, 0));
    tbl.push_back(mk("lb_01",     1, 1, 1, 0, 3'b000, 32'h0000_0001, 32'h0, 32'hFFFF_FFF0, 0));
    tbl.push_back(mk("lhu_02",    1, 1, 1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'h0000_BEEF, 0));
    tbl.push_back(mk("rdwr_both", 1, 1, 1, 1, 3'b010, 32'h0000_0020, 32'h0102_0304, 32'h0, 0));
    tbl.push_back(mk("lw_f3_011", 1, 1, 1, 0, 3'b011, 32'h0000_0020, 32'h0, 32'h0102_0304, 0));
    tbl.push_back(mk("lw_f3_110", 1, 1, 1, 0, 3'b110, 32'h0000_0020, 32'h0, 32'h0102_0304, 0));
    tbl.push_back(mk("lw_f3_111_mis", 1, 1, 1, 0, 3'b111, 32'h0000_0022, 32'h0, 32'h0, 1));
    tbl.push_back(mk("alu_op",    1, 1, 0, 0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0));
    tbl.push_back(mk("invalid",   0, 1, 1, 0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 0));

    idle();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst.valid", 32'(c_valid), 32'd0);
      check("rst.regw",  32'(c_regw),  32'd0);
      check("rst.stall", 32'(c_stall), 32'd0);
      check("rst.alu",   c_alu,        32'd0);
      check("rst.rdata", c_rdata,      32'd0);
      check("rst.mis",   32'(c_mis),   32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Latency-1 instance: table of single-cycle ops.
    sel = 0;
    #1;
    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], 0);

    // Latency-4 instance: stall profile of a load, then an ALU op right behind it.
    sel = 2;
    #1;
    run_op(mk("l4_sw", 1, 0, 0, 1, 3'b010, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 0), 10);
    drive(mk("l4_lw", 1, 1, 1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0));
    #1;
    check("l4_lw.stall_c0", 32'(c_stall), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("l4_lw.bubble_c%0d", k), 32'(c_valid), 32'd0);
      check($sformatf("l4_lw.stall_c%0d", k), 32'(c_stall), (k < 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    compare_front();
    drive(mk("l4_alu", 1, 1, 0, 0, 3'b000, 32'h0000_7777, 32'h0, 32'h0, 0));
    #1;
    check("l4_alu.stall", 32'(c_stall), 32'd0);
    @(posedge clk); #1;
    compare_front();
    idle();
    run_op(mk("l4_lw_mis", 1, 1, 1, 0, 3'b010, 32'h0000_0042, 32'h0, 32'h0, 1), 0);
    run_op(mk("l4_lw_back", 1, 1, 1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0), 10);

    // Latency-3 instance: reset while a store is in flight discards it.
    sel = 1;
    #1;
    run_op(mk("l3_sw_old", 1, 0, 0, 1, 3'b010, 32'h0000_0080, 32'h1111_1111, 32'h0, 0), 10);
    valid_m = 1'b1; mem_write_m = 1'b1; funct3_m = 3'b010;
    alu_result_m = 32'h0000_0080; write_data_m = 32'h2222_2222;
    #1;
    check("l3_pend.stall_c0", 32'(c_stall), 32'd1);
    @(posedge clk); #1;
    check("l3_pend.stall_c1", 32'(c_stall), 32'd1);
    rst = 1'b0;
    #1;
    check("l3_rst.stall", 32'(c_stall), 32'd0);
    idle();
    #1;
    check("l3_rst.valid", 32'(c_valid), 32'd0);
    check("l3_rst.alu",   c_alu,        32'd0);
    check("l3_rst.pc",    c_pc,         32'd0);
    check("l3_rst.rd",    32'(c_rd),    32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(mk("l3_lw_old", 1, 1, 1, 0, 3'b010, 32'h0000_0080, 32'h0, 32'h1111_1111, 0), 10);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
